// File: rtl/md_pkg.sv
// +----------------------------------------------------------------------+
// | md_pkg: shared encodings for the multiply/divide unit                |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_ITER  = MD_WIDTH;

    localparam logic [1:0] MD_OP_MULT  = 2'b00;
    localparam logic [1:0] MD_OP_MULTU = 2'b01;
    localparam logic [1:0] MD_OP_DIV   = 2'b10;
    localparam logic [1:0] MD_OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    typedef enum logic {
        MD_MODE_MUL = 1'b0,
        MD_MODE_DIV = 1'b1
    } md_mode_e;

endpackage

`default_nettype wire

// File: rtl/md_if.sv
// +----------------------------------------------------------------------+
// | md_if: request/result bundle between EX stage and md_unit            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

interface md_if
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             annul;
    logic             stall_o;
    logic             result_valid;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;

    modport master (
        output start, op, src_a, src_b, annul,
        input  stall_o, result_valid, hi_o, lo_o
    );

    modport slave (
        input  start, op, src_a, src_b, annul,
        output stall_o, result_valid, hi_o, lo_o
    );
endinterface

`default_nettype wire

// File: rtl/md_step.sv
// +----------------------------------------------------------------------+
// | md_step: one radix-2 iteration (shift-add multiply or restoring      |
// | shift-subtract divide) on a {hi,lo} accumulator                      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module md_step
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  wire logic [2*WIDTH-1:0] acc_i,
    input  wire logic [WIDTH-1:0]   opnd_i,
    input  md_mode_e                mode_i,
    output logic      [2*WIDTH-1:0] acc_o
);
    localparam int DW = 2*WIDTH;

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        addend = acc_i[0] ? opnd_i : {WIDTH{1'b0}};
        sum    = {1'b0, acc_i[DW-1:WIDTH]} + {1'b0, addend};
        // Partial remainder is always below the divisor, so WIDTH+1 bits hold the shift.
        rem_sh = acc_i[DW-1:WIDTH-1];
        diff   = rem_sh - {1'b0, opnd_i};
        acc_o  = {sum, acc_i[WIDTH-1:1]};
        if (mode_i == MD_MODE_DIV) begin
            if (diff[WIDTH]) begin
                acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
            end else begin
                acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/md_unit.sv
// +----------------------------------------------------------------------+
// | md_unit: multi-cycle MULT/MULTU/DIV/DIVU unit driving the HI/LO      |
// | write port. Define MD_FAST_MUL_EN for a single-cycle multiply path.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = 5
) (
    input  wire logic clk,
    input  wire logic rst,
    md_if.slave       bus
);
    localparam int              DW   = 2*WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH-1);

    md_state_e        state_q, state_d;
    md_mode_e         mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] opb_q, opb_d, raw_a_q, raw_a_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, div0_q, div0_d;
    logic             stall, rvalid;

    logic             is_div, is_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, res_hi, res_lo;

    function automatic logic [WIDTH-1:0] neg_w(input logic c, input logic [WIDTH-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [DW-1:0] neg_dw(input logic c, input logic [DW-1:0] v);
        return c ? (~v + 1'b1) : v;
    endfunction

    md_step #(.WIDTH(WIDTH)) u_step (
        .acc_i  (acc_q),
        .opnd_i (opb_q),
        .mode_i (mode_q),
        .acc_o  (acc_step)
    );

    always_comb begin
        is_div    = (bus.op == MD_OP_DIV) || (bus.op == MD_OP_DIVU);
        is_signed = (bus.op == MD_OP_MULT) || (bus.op == MD_OP_DIV);
        a_neg     = is_signed & bus.src_a[WIDTH-1];
        b_neg     = is_signed & bus.src_b[WIDTH-1];
        a_mag     = neg_w(a_neg, bus.src_a);
        b_mag     = neg_w(b_neg, bus.src_b);
    end

    // Sign correction of the final iteration's output, used on the last BUSY edge.
    always_comb begin
        {res_hi, res_lo} = neg_dw(neg_res_q, acc_step);
        if (mode_q == MD_MODE_DIV) begin
            if (div0_q) begin
                res_hi = raw_a_q;
                res_lo = {WIDTH{1'b1}};
            end else begin
                res_hi = neg_w(neg_rem_q, acc_step[DW-1:WIDTH]);
                res_lo = neg_w(neg_res_q, acc_step[WIDTH-1:0]);
            end
        end
    end

`ifdef MD_FAST_MUL_EN
    logic [DW-1:0] fast_prod;

    always_comb begin
        fast_prod = neg_dw(a_neg ^ b_neg, {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag});
    end
`endif

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        opb_d     = opb_q;
        raw_a_d   = raw_a_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        stall     = 1'b0;
        rvalid    = 1'b0;
        unique case (state_q)
            MD_IDLE: begin
                if (bus.start && !bus.annul) begin
                    stall     = 1'b1;
                    mode_d    = is_div ? MD_MODE_DIV : MD_MODE_MUL;
                    cnt_d     = '0;
                    acc_d     = {{WIDTH{1'b0}}, a_mag};
                    opb_d     = b_mag;
                    raw_a_d   = bus.src_a;
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    div0_d    = (bus.src_b == '0);
                    state_d   = MD_BUSY;
`ifdef MD_FAST_MUL_EN
                    if (!is_div) begin
                        {hi_d, lo_d} = fast_prod;
                        state_d      = MD_DONE;
                    end
`endif
                end
            end
            MD_BUSY: begin
                stall = 1'b1;
                acc_d = acc_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    state_d = MD_DONE;
                end
            end
            MD_DONE: begin
                rvalid  = 1'b1;
                state_d = MD_IDLE;
            end
            default: state_d = MD_IDLE;
        endcase
        // A flush overrides everything: drop the op, keep the architectural HI/LO.
        if (bus.annul) begin
            state_d = MD_IDLE;
            rvalid  = 1'b0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= MD_IDLE;
            mode_q    <= MD_MODE_MUL;
            cnt_q     <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            raw_a_q   <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            opb_q     <= opb_d;
            raw_a_q   <= raw_a_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.stall_o      = stall;
    assign bus.result_valid = rvalid;
    assign bus.hi_o         = hi_q;
    assign bus.lo_o         = lo_q;

endmodule

`default_nettype wire
